// File: rtl/fma_issue_queue.sv
// rtl/fma_issue_queue.sv - in-order FMA operand issue queue with push-time special-case classification
module fma_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic [31:0]                in_c,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_a,
    output logic [31:0]                out_b,
    output logic [31:0]                out_c,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_special,
    output logic [31:0]                out_special_result,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [31:0]      c;
        logic [TAG_W-1:0] tag;
        logic             special;
        logic [31:0]      result;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_r;
    logic [TAG_W-1:0]  tag_ctr;
    logic              push;
    logic              pop;

    logic              a_nan, b_nan, c_nan;
    logic              a_inf, b_inf, c_inf;
    logic              a_zero, b_zero;
    logic              prod_sign;
    logic              cls_special;
    logic [31:0]       cls_result;

    assign in_ready  = (count_r < CW'(DEPTH));
    assign out_valid = (count_r != '0);
    assign count     = count_r;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign a_nan     = (in_a[30:23] == 8'hFF) && (in_a[22:0] != '0);
    assign b_nan     = (in_b[30:23] == 8'hFF) && (in_b[22:0] != '0);
    assign c_nan     = (in_c[30:23] == 8'hFF) && (in_c[22:0] != '0);
    assign a_inf     = (in_a[30:23] == 8'hFF) && (in_a[22:0] == '0);
    assign b_inf     = (in_b[30:23] == 8'hFF) && (in_b[22:0] == '0);
    assign c_inf     = (in_c[30:23] == 8'hFF) && (in_c[22:0] == '0);
    assign a_zero    = (in_a[30:0] == '0);
    assign b_zero    = (in_b[30:0] == '0);
    assign prod_sign = in_a[31] ^ in_b[31];

    // Rules are ordered by priority: NaN inputs, Inf*0, Inf-Inf, signed Inf product, Inf addend.
    always_comb begin
        cls_special = 1'b0;
        cls_result  = '0;
        if (a_nan || b_nan || c_nan) begin
            cls_special = 1'b1;
            cls_result  = QNAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            cls_special = 1'b1;
            cls_result  = QNAN;
        end else if ((a_inf || b_inf) && c_inf && (in_c[31] != prod_sign)) begin
            cls_special = 1'b1;
            cls_result  = QNAN;
        end else if (a_inf || b_inf) begin
            cls_special = 1'b1;
            cls_result  = {prod_sign, 8'hFF, 23'h0};
        end else if (c_inf) begin
            cls_special = 1'b1;
            cls_result  = in_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            tag_ctr <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PW'(1);
                tag_ctr <= tag_ctr + TAG_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_r <= count_r + CW'(1);
            end else if (pop && !push) begin
                count_r <= count_r - CW'(1);
            end
        end
    end

    // Entry storage carries no reset; out_valid gating hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_a, b: in_b, c: in_c, tag: tag_ctr,
                             special: cls_special, result: cls_result};
        end
    end

    assign head               = mem[rd_ptr];
    assign out_a              = out_valid ? head.a       : '0;
    assign out_b              = out_valid ? head.b       : '0;
    assign out_c              = out_valid ? head.c       : '0;
    assign out_tag            = out_valid ? head.tag     : '0;
    assign out_special        = out_valid ? head.special : 1'b0;
    assign out_special_result = out_valid ? head.result  : '0;

endmodule

// File: tb/tb_fma_issue_queue.sv
// tb/tb_fma_issue_queue.sv - randomized and directed bench for fma_issue_queue against a queue model
module tb_fma_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0, in_b = '0, in_c = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_a, out_b, out_c;
    logic [TAG_W-1:0] out_tag;
    logic             out_special;
    logic [31:0]      out_special_result;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a, b, c;
        int          tag;
        logic        sp;
        logic [31:0] res;
    } ent_t;

    ent_t q[$];
    int   mtag = 0;

    always #5 clk = ~clk;

    fma_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c),
        .out_tag(out_tag), .out_special(out_special),
        .out_special_result(out_special_result),
        .count(count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_nan(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] != 0;
    endfunction
    function automatic bit is_inf(input logic [31:0] x);
        return x[30:23] == 8'hFF && x[22:0] == 0;
    endfunction
    function automatic bit is_zero(input logic [31:0] x);
        return x[30:0] == 0;
    endfunction

    // Returns {special, result} from the IEEE special-value rules.
    function automatic logic [32:0] ref_cls(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        bit psign;
        bit pinf;
        psign = a[31] ^ b[31];
        pinf  = is_inf(a) || is_inf(b);
        if (is_nan(a) || is_nan(b) || is_nan(c)) return {1'b1, 32'h7FC00000};
        if ((is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a))) return {1'b1, 32'h7FC00000};
        if (pinf && is_inf(c) && (c[31] != psign)) return {1'b1, 32'h7FC00000};
        if (pinf) return {1'b1, psign, 8'hFF, 23'h0};
        if (is_inf(c)) return {1'b1, c};
        return 33'h0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            mtag = 0;
        end else begin
            bit   do_push;
            bit   do_pop;
            ent_t e;
            logic [32:0] cl;
            do_push = in_valid && (q.size() < DEPTH);
            do_pop  = out_ready && (q.size() > 0);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                cl    = ref_cls(in_a, in_b, in_c);
                e.a   = in_a;
                e.b   = in_b;
                e.c   = in_c;
                e.tag = mtag;
                e.sp  = cl[32];
                e.res = cl[31:0];
                q.push_back(e);
                mtag = (mtag + 1) % (1 << TAG_W);
            end
        end
    end

    always @(negedge clk) begin
        check("in_ready", in_ready, q.size() < DEPTH);
        check("out_valid", out_valid, q.size() != 0);
        check("count", count, q.size());
        if (q.size() > 0) begin
            check("out_a", out_a, q[0].a);
            check("out_b", out_b, q[0].b);
            check("out_c", out_c, q[0].c);
            check("out_tag", out_tag, q[0].tag);
            check("out_special", out_special, q[0].sp);
            check("out_special_result", out_special_result, q[0].res);
        end else begin
            check("idle_data", {out_a, out_b}, 64'h0);
            check("idle_misc", {out_c, out_tag, out_special, out_special_result}, 0);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] pool [8];
        pool = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00001, 32'h3F800000, 32'hBF800000, 32'h40490FDB};
        if ($urandom_range(0, 3) == 0) return $urandom;
        return pool[$urandom_range(0, 7)];
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        cyc();
        cyc();
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b1;

        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_c = 32'h3F800000;
        cyc();
        in_valid = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_tag", out_tag, 0);
        check("single_special", out_special, 0);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("single_pop_count", count, 0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
            cyc();
        end
        in_valid = 1'b0;
        check("fill_count", count, 4);
        check("fill_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_tag", out_tag, i);
            cyc();
        end
        out_ready = 1'b0;
        check("drain_empty", out_valid, 0);

        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_a = $urandom; in_b = $urandom; in_c = $urandom;
            cyc();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a = $urandom; in_b = $urandom; in_c = $urandom;
            cyc();
            check("steady_count", count, 2);
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        out_ready = 1'b0;

        do_reset();
        in_valid = 1'b1;
        in_a = 32'h7F800000; in_b = 32'h00000000; in_c = 32'h3F800000; cyc();
        in_a = 32'hFF800000; in_b = 32'h3F800000; in_c = 32'h00000000; cyc();
        in_a = 32'h7F800000; in_b = 32'h3F800000; in_c = 32'hFF800000; cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("sp0_flag", out_special, 1);
        check("sp0_res", out_special_result, 32'h7FC00000);
        cyc();
        check("sp1_flag", out_special, 1);
        check("sp1_res", out_special_result, 32'hFF800000);
        check("sp1_tag", out_tag, 1);
        cyc();
        check("sp2_flag", out_special, 1);
        check("sp2_res", out_special_result, 32'h7FC00000);
        cyc();
        out_ready = 1'b0;

        do_reset();
        for (int i = 1; i <= 17; i++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = 32'h3F800000; in_c = 32'h0;
            cyc();
            in_valid = 1'b0;
            if (i == 16) check("wrap_tag15", out_tag, 15);
            if (i == 17) check("wrap_tag17", out_tag, 0);
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
        end

        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
            cyc();
        end
        in_valid = 1'b0;
        check("pre_rst_count", count, 3);
        rst = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_count", count, 0);
        cyc();
        rst = 1'b1;
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000; in_c = 32'h3F800000;
        cyc();
        in_valid = 1'b0;
        check("post_rst_tag", out_tag, 0);
        out_ready = 1'b1;
        cyc();

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                cyc();
                rst = 1'b1;
            end
            in_valid  = $urandom_range(0, 99) < 60;
            out_ready = $urandom_range(0, 99) < 50;
            in_a = rand_op(); in_b = rand_op(); in_c = rand_op();
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fma_issue_queue.md
FMA_ISSUE_QUEUE -- requirements
Module: fma_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries, power of two, at least 2.
REQ-002 SHALL have parameter TAG_W, default 4, operation tag width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operand triple offered.
REQ-007 SHALL have port in_ready, output, 1 bit: queue accepts the triple this cycle.
REQ-008 SHALL have ports in_a, in_b, in_c, input, 32 bits each: binary32 operands of a*b+c.
REQ-009 SHALL have port out_valid, output, 1 bit: head entry presented to FMA stage 1.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream takes the head entry.
REQ-011 SHALL have ports out_a, out_b, out_c, output, 32 bits each: head operands.
REQ-012 SHALL have port out_tag, output, TAG_W bits: issue sequence number of the head entry.
REQ-013 SHALL have port out_special, output, 1 bit: head needs no arithmetic; use out_special_result.
REQ-014 SHALL have port out_special_result, output, 32 bits: bypass result, valid when out_special=1.
REQ-015 SHALL have port count, output, log2(DEPTH)+1 bits: current occupancy.

Function
REQ-016 SHALL accept an entry when in_valid and in_ready are both 1 at a rising edge; SHALL remove the head when out_valid and out_ready are both 1.
REQ-017 SHALL drive in_ready = (count < DEPTH), with no dependence on out_ready; pushing into a full queue is never possible.
REQ-018 SHALL drive out_valid = (count != 0); there is no empty bypass, so accept-to-out_valid latency is exactly 1 cycle.
REQ-019 SHALL be a circular buffer with write and read pointers of log2(DEPTH) bits that wrap modulo DEPTH; occupancy is tracked in count.
REQ-020 SHALL change count as follows on simultaneous push and pop: unchanged. Push only: +1. Pop only: -1.
REQ-021 SHALL keep head outputs stable while out_valid=1 and out_ready=0.
REQ-022 SHALL hold a TAG_W-bit issue counter; each accepted push stores the counter value with the entry and increments it modulo 2^TAG_W.
REQ-023 SHALL classify each entry at push time and store out_special and out_special_result alongside the operands; the classification is purely combinational on in_a, in_b, in_c.
REQ-024 SHALL apply the following classification rules:
  - Any operand NaN (exp=0xFF, man!=0): special, result 0x7FC00000.
  - a or b is Inf and the other is zero (exp=0, man=0): special, result 0x7FC00000.
  - Product Inf and c Inf with opposite signs: special, result 0x7FC00000.
  - Product Inf, otherwise: special, result {sign_a^sign_b, 0xFF, 23'b0}.
  - c Inf with a finite product: special, result c.
  - Otherwise: out_special=0 and out_special_result=0.
REQ-025 SHALL define the product sign as sign_a XOR sign_b.
REQ-026 SHALL keep special entries in order and tagged like arithmetic entries; they are never dropped or reordered.
REQ-027 SHALL keep head outputs at 0 while out_valid=0.

Reset
REQ-028 SHALL, while rst=0 and asynchronously on assertion, set the following: count=0, pointers=0, tag counter=0, out_valid=0, out_* data=0, and in_ready=1 after release.
REQ-029 SHALL discard all queued entries on reset asserted mid-operation; the first push after release carries tag 0.
REQ-030 SHALL NOT require the entry storage array to be reset; only the control state is.

Verification
REQ-031 SHALL cover single push then pop: push (0x3F800000, 0x40000000, 0x3F800000) -> next cycle out_valid=1, out_tag=0, out_special=0; pop -> count=0.
REQ-032 SHALL cover fill and stall: out_ready=0 with 5 pushes offered -> 4 accepted, in_ready=0 at count=4, tags 0..3; then drain -> outputs appear in order with tags 0,1,2,3.
REQ-033 SHALL cover simultaneous push and pop at count=2 -> count stays 2, and the pointers wrap correctly over 10 such cycles.
REQ-034 SHALL cover the special cases:
  - a=0x7F800000, b=0x00000000 -> out_special=1, result 0x7FC00000.
  - a=0xFF800000, b=0x3F800000, c=0x00000000 -> result 0xFF800000.
  - a=0x7F800000, b=0x3F800000, c=0xFF800000 -> result 0x7FC00000.
REQ-035 SHALL cover tag wrap: 17 push/pop pairs -> the 17th entry carries tag 0.
REQ-036 SHALL cover reset at count=3: assert rst=0 for one cycle -> immediately out_valid=0 and count=0; the next push carries tag 0.
